// File: rtl/edge_meas_pkg.sv
// Shared types and constants for the edge period meter: FSM state encoding,
// default counter width and the all-ones saturation value.
package edge_meas_pkg;

    localparam int CNT_W_DEF = 16;

    // Wide enough for any supported counter width; users slice the low CNT_W bits.
    localparam logic [63:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } meas_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with clear-to-0, load-to-1 and increment controls.
// at_max_o flags the all-ones value; the counter never wraps past it.
module sat_counter
    import edge_meas_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             load1_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             at_max_o
);

    localparam logic [CNT_W-1:0] MAX_VAL = CNT_MAX[CNT_W-1:0];

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign at_max_o = (cnt_q == MAX_VAL);
    assign cnt_o    = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load1_i) begin
            cnt_d = CNT_W'(1);
        end else if (inc_i && !at_max_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/edge_period_meter.sv
// Measures period (pos to pos) and high time (pos to first neg) of a monitored
// signal from edge-detector pulses; results leave on a valid/ready register.
module edge_period_meter
    import edge_meas_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             pos_pulse,
    input  logic             neg_pulse,
    output logic [CNT_W-1:0] meas_period,
    output logic [CNT_W-1:0] meas_high,
    output logic             meas_overrun,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic             timeout
);

    meas_state_t      state_q, state_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             neg_seen_q, neg_seen_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] mhigh_q, mhigh_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             timeout_q, timeout_d;

    logic             cnt_clr;
    logic             cnt_load;
    logic             cnt_inc;
    logic [CNT_W-1:0] cnt;
    logic             cnt_at_max;
    logic             capture;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (cnt_clr),
        .load1_i  (cnt_load),
        .inc_i    (cnt_inc),
        .cnt_o    (cnt),
        .at_max_o (cnt_at_max)
    );

    always_comb begin
        state_d    = state_q;
        high_d     = high_q;
        neg_seen_d = neg_seen_q;
        timeout_d  = 1'b0;
        cnt_clr    = 1'b0;
        cnt_load   = 1'b0;
        cnt_inc    = 1'b0;
        capture    = 1'b0;

        if (!en) begin
            state_d    = IDLE;
            cnt_clr    = 1'b1;
            neg_seen_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_clr = 1'b1;
                    state_d = ARM;
                end
                ARM: begin
                    if (pos_pulse) begin
                        cnt_load   = 1'b1;
                        neg_seen_d = 1'b0;
                        state_d    = MEASURE;
                    end
                end
                MEASURE: begin
                    // A neg coinciding with pos is deliberately dropped here.
                    if (pos_pulse) begin
                        capture    = 1'b1;
                        cnt_load   = 1'b1;
                        neg_seen_d = 1'b0;
                    end else if (cnt_at_max) begin
                        timeout_d  = 1'b1;
                        cnt_clr    = 1'b1;
                        neg_seen_d = 1'b0;
                        state_d    = ARM;
                    end else begin
                        cnt_inc = 1'b1;
                        if (neg_pulse && !neg_seen_q) begin
                            high_d     = cnt;
                            neg_seen_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_clr = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        period_d  = period_q;
        mhigh_d   = mhigh_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (capture) begin
            period_d  = cnt;
            mhigh_d   = neg_seen_q ? high_q : '0;
            valid_d   = 1'b1;
            overrun_d = valid_q & ~meas_ready;
        end else if (valid_q && meas_ready) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            high_q     <= '0;
            neg_seen_q <= 1'b0;
            period_q   <= '0;
            mhigh_q    <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            high_q     <= high_d;
            neg_seen_q <= neg_seen_d;
            period_q   <= period_d;
            mhigh_q    <= mhigh_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
            timeout_q  <= timeout_d;
        end
    end

    assign meas_period  = period_q;
    assign meas_high    = mhigh_q;
    assign meas_valid   = valid_q;
    assign meas_overrun = overrun_q;
    assign timeout      = timeout_q;

endmodule
